// File: rtl/ahb_arbiter_rr.sv
// ahb_arbiter_rr: parametrised AHB bus arbiter.
// Supports fixed-priority or round-robin winner selection and a burst-length
// fairness limit for unlocked owners. A SPLIT response masks the current
// owner until the slave pulses its HSPLIT bit.
// The grant vector, HMASTER and HMASTLOCK are all registered outputs.
module ahb_arbiter_rr #(
  parameter int NUM_MASTERS     = 16,
  parameter int ARB_MODE        = 1,
  parameter int DEFAULT_MASTER  = 0,
  parameter int MAX_BURST_BEATS = 16
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [NUM_MASTERS-1:0]           HBUSREQx,
  input  logic [NUM_MASTERS-1:0]           HLOCKx,
  input  logic [NUM_MASTERS-1:0]           HSPLIT,
  input  logic                             HREADY,
  input  logic [1:0]                       HTRANS,
  input  logic [1:0]                       HRESP,
  output logic [NUM_MASTERS-1:0]           HGRANTx,
  output logic [$clog2(NUM_MASTERS)-1:0]   HMASTER,
  output logic                             HMASTLOCK
);

  localparam int MW = $clog2(NUM_MASTERS);
  localparam int BW = 8;
  localparam logic [MW-1:0]          DEF_IDX    = MW'(DEFAULT_MASTER);
  localparam logic [MW-1:0]          LAST_IDX   = MW'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT  = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [BW-1:0]          BEAT_LIMIT = BW'(MAX_BURST_BEATS);
  localparam logic [1:0]             RESP_SPLIT = 2'b11;

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          master_q, master_d;
  logic                   mastlock_q, mastlock_d;
  logic [NUM_MASTERS-1:0] split_q, split_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [MW-1:0]          rr_q, rr_d;

  logic [MW-1:0]          cur;
  logic [MW-1:0]          winner;
  logic                   found;
  int                     idx;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   hold;
  logic                   expired;
  logic                   rearb;
  logic                   unused_htrans;

  // Only HTRANS[1] distinguishes an active beat (NONSEQ/SEQ) from IDLE/BUSY.
  assign unused_htrans = HTRANS[0];

  // Decode the one-hot grant register back into the current owner index.
  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[MW'(i)]) cur = MW'(i);
    end
  end

  assign eligible = HBUSREQx & ~split_q;
  // A locked, requesting, unmasked owner keeps the bus regardless of beat count.
  assign hold     = HBUSREQx[cur] && HLOCKx[cur] && !split_q[cur];
  assign expired  = (beat_q == BEAT_LIMIT);
  assign rearb    = HREADY && !hold && (!HBUSREQx[cur] || split_q[cur] || expired);

  // Pick the next owner: lowest eligible index, or first eligible at/after rr_q.
  always_comb begin
    winner = DEF_IDX;
    found  = 1'b0;
    idx    = 0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (eligible[MW'(i)]) begin
          winner = MW'(i);
          found  = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
        if (!found && eligible[MW'(idx)]) begin
          winner = MW'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  // Next-state for grant, beat counter, pointer, split mask and address-phase owner.
  // The beat counter restarts on every re-arbitration, so an owner that re-wins
  // after expiry starts a fresh tenure of MAX_BURST_BEATS beats.
  always_comb begin
    grant_d    = grant_q;
    rr_d       = rr_q;
    beat_d     = beat_q;
    master_d   = master_q;
    mastlock_d = mastlock_q;
    split_d    = split_q & ~HSPLIT;
    if (HRESP == RESP_SPLIT && !HREADY) split_d[master_q] = 1'b1;
    if (rearb) begin
      grant_d         = '0;
      grant_d[winner] = 1'b1;
      beat_d          = '0;
      if (winner != cur && HBUSREQx[winner]) begin
        rr_d = (winner == LAST_IDX) ? '0 : winner + 1'b1;
      end
    end else if (HREADY && HTRANS[1] && beat_q < BEAT_LIMIT) begin
      beat_d = beat_q + 1'b1;
    end
    if (HREADY) begin
      master_d   = cur;
      mastlock_d = HLOCKx[cur] && HBUSREQx[cur];
    end
  end

  // State registers; reset returns ownership to the default master with no masks.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      grant_q    <= DEF_GRANT;
      master_q   <= DEF_IDX;
      mastlock_q <= 1'b0;
      split_q    <= '0;
      beat_q     <= '0;
      rr_q       <= '0;
    end else begin
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
      split_q    <= split_d;
      beat_q     <= beat_d;
      rr_q       <= rr_d;
    end
  end

  assign HGRANTx   = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// tb_ahb_arbiter_rr: directed bench for the AHB arbiter.
// Two instances share all inputs: a round-robin one and a fixed-priority one,
// both with 16 masters, default master 0 and a 4-beat burst limit.
module tb_ahb_arbiter_rr;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic [15:0] HBUSREQx;
  logic [15:0] HLOCKx;
  logic [15:0] HSPLIT;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic [1:0]  HRESP;

  logic [15:0] gntRr, gntFp;
  logic [3:0]  mstRr, mstFp;
  logic        lckRr, lckFp;

  int testsRun = 0;
  int failCount = 0;

  ahb_arbiter_rr #(
    .NUM_MASTERS(16), .ARB_MODE(1), .DEFAULT_MASTER(0), .MAX_BURST_BEATS(4)
  ) u_rr (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx),
    .HSPLIT(HSPLIT), .HREADY(HREADY), .HTRANS(HTRANS), .HRESP(HRESP),
    .HGRANTx(gntRr), .HMASTER(mstRr), .HMASTLOCK(lckRr)
  );

  ahb_arbiter_rr #(
    .NUM_MASTERS(16), .ARB_MODE(0), .DEFAULT_MASTER(0), .MAX_BURST_BEATS(4)
  ) u_fp (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx),
    .HSPLIT(HSPLIT), .HREADY(HREADY), .HTRANS(HTRANS), .HRESP(HRESP),
    .HGRANTx(gntFp), .HMASTER(mstFp), .HMASTLOCK(lckFp)
  );

  // Free-running 10-unit bus clock.
  always #5 HCLK = ~HCLK;

  // Advance to just after the next rising edge, where outputs are sampled and inputs driven.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    HBUSREQx = '0;
    HLOCKx   = '0;
    HSPLIT   = '0;
    HREADY   = 1'b1;
    HTRANS   = 2'b00;
    HRESP    = 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2;
    HRESET = 1'b1;
    #2;
    testsRun++; if (gntRr !== 16'h0001) begin failCount++; $display("[TB] FAIL reset_async_grant_rr: got %h expected %h", gntRr, 16'h0001); end
    testsRun++; if (mstRr !== 4'd0) begin failCount++; $display("[TB] FAIL reset_async_master_rr: got %0d expected 0", mstRr); end
    testsRun++; if (lckRr !== 1'b0) begin failCount++; $display("[TB] FAIL reset_async_lock_rr: got %b expected 0", lckRr); end
    testsRun++; if (gntFp !== 16'h0001) begin failCount++; $display("[TB] FAIL reset_async_grant_fp: got %h expected %h", gntFp, 16'h0001); end
    testsRun++; if (mstFp !== 4'd0) begin failCount++; $display("[TB] FAIL reset_async_master_fp: got %0d expected 0", mstFp); end
    testsRun++; if (lckFp !== 1'b0) begin failCount++; $display("[TB] FAIL reset_async_lock_fp: got %b expected 0", lckFp); end
    tick();
    tick();
    HRESET = 1'b0;
    repeat (3) tick();
    testsRun++; if (gntRr !== 16'h0001) begin failCount++; $display("[TB] FAIL reset_idle_grant_rr: got %h expected %h", gntRr, 16'h0001); end
    testsRun++; if (mstRr !== 4'd0) begin failCount++; $display("[TB] FAIL reset_idle_master_rr: got %0d expected 0", mstRr); end
    testsRun++; if (lckRr !== 1'b0) begin failCount++; $display("[TB] FAIL reset_idle_lock_rr: got %b expected 0", lckRr); end
    testsRun++; if (gntFp !== 16'h0001) begin failCount++; $display("[TB] FAIL reset_idle_grant_fp: got %h expected %h", gntFp, 16'h0001); end
    testsRun++; if (mstFp !== 4'd0) begin failCount++; $display("[TB] FAIL reset_idle_master_fp: got %0d expected 0", mstFp); end
    testsRun++; if (lckFp !== 1'b0) begin failCount++; $display("[TB] FAIL reset_idle_lock_fp: got %b expected 0", lckFp); end
  endtask

  // Masters 1..3 stream NONSEQ beats; each tenure lasts five edges
  // (grant edge plus four counted beats, then the expiry edge re-arbitrates).
  task automatic test_round_robin();
    int curIdx;
    int prevIdx;
    logic [15:0] expG;
    do_reset();
    HBUSREQx = 16'h000E;
    HTRANS   = 2'b10;
    prevIdx  = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      case ((k - 1) / 5)
        0:       curIdx = 1;
        1:       curIdx = 2;
        2:       curIdx = 3;
        default: curIdx = 1;
      endcase
      expG = 16'h0001 << curIdx;
      testsRun++; if (gntRr !== expG) begin failCount++; $display("[TB] FAIL rr_grant edge %0d: got %h expected %h", k, gntRr, expG); end
      testsRun++; if (mstRr !== 4'(prevIdx)) begin failCount++; $display("[TB] FAIL rr_master edge %0d: got %0d expected %0d", k, mstRr, prevIdx); end
      testsRun++; if (gntFp !== 16'h0002) begin failCount++; $display("[TB] FAIL fp_grant edge %0d: got %h expected %h", k, gntFp, 16'h0002); end
      testsRun++; if (mstFp !== ((k == 1) ? 4'd0 : 4'd1)) begin failCount++; $display("[TB] FAIL fp_master edge %0d: got %0d expected %0d", k, mstFp, (k == 1) ? 0 : 1); end
      prevIdx = curIdx;
    end
  endtask

  // Master 2 locks the bus for 20 beats while master 1 waits.
  task automatic test_locked_hold();
    do_reset();
    HBUSREQx = 16'h0004;
    HLOCKx   = 16'h0004;
    HTRANS   = 2'b10;
    tick();
    testsRun++; if (gntRr !== 16'h0004) begin failCount++; $display("[TB] FAIL lock_first_grant_rr: got %h expected %h", gntRr, 16'h0004); end
    testsRun++; if (gntFp !== 16'h0004) begin failCount++; $display("[TB] FAIL lock_first_grant_fp: got %h expected %h", gntFp, 16'h0004); end
    HBUSREQx = 16'h0006;
    for (int b = 0; b < 20; b++) begin
      tick();
      testsRun++; if (gntRr !== 16'h0004) begin failCount++; $display("[TB] FAIL lock_hold_rr beat %0d: got %h expected %h", b, gntRr, 16'h0004); end
      testsRun++; if (gntFp !== 16'h0004) begin failCount++; $display("[TB] FAIL lock_hold_fp beat %0d: got %h expected %h", b, gntFp, 16'h0004); end
      testsRun++; if (lckRr !== 1'b1) begin failCount++; $display("[TB] FAIL lock_mastlock beat %0d: got %b expected 1", b, lckRr); end
      testsRun++; if (mstRr !== 4'd2) begin failCount++; $display("[TB] FAIL lock_master beat %0d: got %0d expected 2", b, mstRr); end
    end
    HBUSREQx = 16'h0002;
    HLOCKx   = 16'h0000;
    tick();
    testsRun++; if (gntRr !== 16'h0002) begin failCount++; $display("[TB] FAIL lock_release_rr: got %h expected %h", gntRr, 16'h0002); end
    testsRun++; if (gntFp !== 16'h0002) begin failCount++; $display("[TB] FAIL lock_release_fp: got %h expected %h", gntFp, 16'h0002); end
    testsRun++; if (lckRr !== 1'b0) begin failCount++; $display("[TB] FAIL lock_release_mastlock: got %b expected 0", lckRr); end
  endtask

  // Master 3 is split, loses the bus, is masked until HSPLIT, then regains it.
  // The second split collides with an HSPLIT pulse; the set must win.
  task automatic test_split();
    do_reset();
    HBUSREQx = 16'h0008;
    tick();
    testsRun++; if (gntRr !== 16'h0008) begin failCount++; $display("[TB] FAIL split_own_rr: got %h expected %h", gntRr, 16'h0008); end
    HBUSREQx = 16'h0028;
    tick();
    testsRun++; if (mstRr !== 4'd3) begin failCount++; $display("[TB] FAIL split_master_rr: got %0d expected 3", mstRr); end
    HRESP  = 2'b11;
    HREADY = 1'b0;
    tick();
    testsRun++; if (gntRr !== 16'h0008) begin failCount++; $display("[TB] FAIL split_wait_rr: got %h expected %h", gntRr, 16'h0008); end
    HREADY = 1'b1;
    tick();
    testsRun++; if (gntRr !== 16'h0020) begin failCount++; $display("[TB] FAIL split_move_rr: got %h expected %h", gntRr, 16'h0020); end
    testsRun++; if (gntFp !== 16'h0020) begin failCount++; $display("[TB] FAIL split_move_fp: got %h expected %h", gntFp, 16'h0020); end
    HRESP    = 2'b00;
    HBUSREQx = 16'h0008;
    tick();
    testsRun++; if (gntRr !== 16'h0001) begin failCount++; $display("[TB] FAIL split_masked_rr: got %h expected %h", gntRr, 16'h0001); end
    testsRun++; if (gntFp !== 16'h0001) begin failCount++; $display("[TB] FAIL split_masked_fp: got %h expected %h", gntFp, 16'h0001); end
    HSPLIT = 16'h0008;
    tick();
    HSPLIT = 16'h0000;
    tick();
    testsRun++; if (gntRr !== 16'h0008) begin failCount++; $display("[TB] FAIL split_resume_rr: got %h expected %h", gntRr, 16'h0008); end
    testsRun++; if (gntFp !== 16'h0008) begin failCount++; $display("[TB] FAIL split_resume_fp: got %h expected %h", gntFp, 16'h0008); end
    HBUSREQx = 16'h0028;
    tick();
    testsRun++; if (mstRr !== 4'd3) begin failCount++; $display("[TB] FAIL split2_master_rr: got %0d expected 3", mstRr); end
    HRESP  = 2'b11;
    HREADY = 1'b0;
    HSPLIT = 16'h0008;
    tick();
    HSPLIT = 16'h0000;
    HREADY = 1'b1;
    tick();
    testsRun++; if (gntRr !== 16'h0020) begin failCount++; $display("[TB] FAIL split_setwins_rr: got %h expected %h", gntRr, 16'h0020); end
    testsRun++; if (gntFp !== 16'h0020) begin failCount++; $display("[TB] FAIL split_setwins_fp: got %h expected %h", gntFp, 16'h0020); end
    HRESP    = 2'b00;
    HBUSREQx = 16'h0008;
    tick();
    testsRun++; if (gntRr !== 16'h0001) begin failCount++; $display("[TB] FAIL split2_masked_rr: got %h expected %h", gntRr, 16'h0001); end
    HSPLIT = 16'h0008;
    tick();
    HSPLIT = 16'h0000;
    tick();
    testsRun++; if (gntRr !== 16'h0008) begin failCount++; $display("[TB] FAIL split2_resume_rr: got %h expected %h", gntRr, 16'h0008); end
    testsRun++; if (gntFp !== 16'h0008) begin failCount++; $display("[TB] FAIL split2_resume_fp: got %h expected %h", gntFp, 16'h0008); end
  endtask

  // Mask master 4, hand a locked burst to master 1, then reset between edges.
  task automatic test_async_reset();
    do_reset();
    HBUSREQx = 16'h0010;
    HTRANS   = 2'b10;
    tick();
    tick();
    HRESP  = 2'b11;
    HREADY = 1'b0;
    tick();
    HRESP    = 2'b00;
    HREADY   = 1'b1;
    HBUSREQx = 16'h0012;
    tick();
    testsRun++; if (gntRr !== 16'h0002) begin failCount++; $display("[TB] FAIL areset_pre_grant_rr: got %h expected %h", gntRr, 16'h0002); end
    HLOCKx = 16'h0002;
    tick();
    tick();
    testsRun++; if (lckRr !== 1'b1) begin failCount++; $display("[TB] FAIL areset_pre_lock_rr: got %b expected 1", lckRr); end
    #2;
    HRESET = 1'b1;
    #1;
    testsRun++; if (gntRr !== 16'h0001) begin failCount++; $display("[TB] FAIL areset_grant_rr: got %h expected %h", gntRr, 16'h0001); end
    testsRun++; if (mstRr !== 4'd0) begin failCount++; $display("[TB] FAIL areset_master_rr: got %0d expected 0", mstRr); end
    testsRun++; if (lckRr !== 1'b0) begin failCount++; $display("[TB] FAIL areset_lock_rr: got %b expected 0", lckRr); end
    testsRun++; if (gntFp !== 16'h0001) begin failCount++; $display("[TB] FAIL areset_grant_fp: got %h expected %h", gntFp, 16'h0001); end
    HLOCKx   = 16'h0000;
    HBUSREQx = 16'h0010;
    #1;
    HRESET = 1'b0;
    tick();
    testsRun++; if (gntRr !== 16'h0010) begin failCount++; $display("[TB] FAIL areset_mask_clear_rr: got %h expected %h", gntRr, 16'h0010); end
    testsRun++; if (gntFp !== 16'h0010) begin failCount++; $display("[TB] FAIL areset_mask_clear_fp: got %h expected %h", gntFp, 16'h0010); end
  endtask

  // Run every scenario in order and report.
  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_locked_hold();
    test_split();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
